// File: rtl/pipe_ctrl_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_regs_if
// Description : Bundle of signals between the decode stage / hazard unit and
//               the E/M/W pipeline control register chain.
//               master modport : driver side (decode stage, hazard unit,
//                                DES freeze, debug counter clear)
//               slave  modport : pipe_ctrl_regs side (captures D-stage
//                                fields, presents E/M/W stage state and the
//                                stall/flush event counters)
//               Ports summary:
//                 D-side in : freeze, stall_D, flush_E, rs_D, rt_D, rd_D,
//                             regdst_D, regwrite_D, memtoreg_D, memwrite_D,
//                             clr_cnt
//                 E/M/W out : rs_E, rt_E, writereg_E/M/W, regwrite_E/M/W,
//                             memtoreg_E/M/W, memwrite_E/M, valid_E/M/W,
//                             stall_cnt, flush_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_regs_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) ();

    // Controls from the hazard unit / coprocessor / debug.
    logic             freeze;
    logic             stall_D;
    logic             flush_E;
    logic             clr_cnt;

    // Decode-stage instruction fields.
    logic [REG_W-1:0] rs_D;
    logic [REG_W-1:0] rt_D;
    logic [REG_W-1:0] rd_D;
    logic             regdst_D;
    logic             regwrite_D;
    logic             memtoreg_D;
    logic             memwrite_D;

    // Execute stage.
    logic [REG_W-1:0] rs_E;
    logic [REG_W-1:0] rt_E;
    logic [REG_W-1:0] writereg_E;
    logic             regwrite_E;
    logic             memtoreg_E;
    logic             memwrite_E;
    logic             valid_E;

    // Memory stage.
    logic [REG_W-1:0] writereg_M;
    logic             regwrite_M;
    logic             memtoreg_M;
    logic             memwrite_M;
    logic             valid_M;

    // Writeback stage.
    logic [REG_W-1:0] writereg_W;
    logic             regwrite_W;
    logic             memtoreg_W;
    logic             valid_W;

    // Debug event counters.
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output freeze, stall_D, flush_E, clr_cnt,
        output rs_D, rt_D, rd_D, regdst_D, regwrite_D, memtoreg_D, memwrite_D,
        input  rs_E, rt_E, writereg_E, regwrite_E, memtoreg_E, memwrite_E, valid_E,
        input  writereg_M, regwrite_M, memtoreg_M, memwrite_M, valid_M,
        input  writereg_W, regwrite_W, memtoreg_W, valid_W,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, stall_D, flush_E, clr_cnt,
        input  rs_D, rt_D, rd_D, regdst_D, regwrite_D, memtoreg_D, memwrite_D,
        output rs_E, rt_E, writereg_E, regwrite_E, memtoreg_E, memwrite_E, valid_E,
        output writereg_M, regwrite_M, memtoreg_M, memwrite_M, valid_M,
        output writereg_W, regwrite_W, memtoreg_W, valid_W,
        output stall_cnt, flush_cnt
    );

endinterface : pipe_ctrl_regs_if
`default_nettype wire

// File: rtl/pipe_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_regs
// Description : E/M/W control register chain of the 5-stage MIPS core.
//               Carries decode control bits and register addresses down the
//               pipe, inserts an E-stage bubble on flush_E, holds everything
//               on the DES freeze, and keeps saturating stall/flush event
//               counters for debug.
//               Ports:
//                 clk   : core clock, rising-edge active
//                 reset : synchronous, active-low reset
//                 bus   : pipe_ctrl_regs_if.slave (D-stage fields, hazard
//                         controls, E/M/W stage state, event counters)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_regs #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pipe_ctrl_regs_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_W-1:0] c_REG_ZERO = '0;

    // ------------------------------------------------------------------
    // Stage registers (_q) and their next-state values (_d)
    // ------------------------------------------------------------------
    // E stage
    logic [REG_W-1:0] rs_E_q,       rs_E_d;
    logic [REG_W-1:0] rt_E_q,       rt_E_d;
    logic [REG_W-1:0] rd_E_q,       rd_E_d;
    logic             regdst_E_q,   regdst_E_d;
    logic             regwrite_E_q, regwrite_E_d;
    logic             memtoreg_E_q, memtoreg_E_d;
    logic             memwrite_E_q, memwrite_E_d;
    logic             valid_E_q,    valid_E_d;

    // M stage
    logic [REG_W-1:0] writereg_M_q, writereg_M_d;
    logic             regwrite_M_q, regwrite_M_d;
    logic             memtoreg_M_q, memtoreg_M_d;
    logic             memwrite_M_q, memwrite_M_d;
    logic             valid_M_q,    valid_M_d;

    // W stage
    logic [REG_W-1:0] writereg_W_q, writereg_W_d;
    logic             regwrite_W_q, regwrite_W_d;
    logic             memtoreg_W_q, memtoreg_W_d;
    logic             valid_W_q,    valid_W_d;

    // Event counters
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    // Destination of the instruction in E, resolved from E registers only so
    // there is no path from any D input to an output.
    logic [REG_W-1:0] writereg_E_w;
    assign writereg_E_w = regdst_E_q ? rd_E_q : rt_E_q;

    // ------------------------------------------------------------------
    // Pipeline next state
    // ------------------------------------------------------------------
    always_comb begin
        // Default: hold (this is also the freeze behaviour).
        rs_E_d       = rs_E_q;
        rt_E_d       = rt_E_q;
        rd_E_d       = rd_E_q;
        regdst_E_d   = regdst_E_q;
        regwrite_E_d = regwrite_E_q;
        memtoreg_E_d = memtoreg_E_q;
        memwrite_E_d = memwrite_E_q;
        valid_E_d    = valid_E_q;

        writereg_M_d = writereg_M_q;
        regwrite_M_d = regwrite_M_q;
        memtoreg_M_d = memtoreg_M_q;
        memwrite_M_d = memwrite_M_q;
        valid_M_d    = valid_M_q;

        writereg_W_d = writereg_W_q;
        regwrite_W_d = regwrite_W_q;
        memtoreg_W_d = memtoreg_W_q;
        valid_W_d    = valid_W_q;

        if (!bus.freeze) begin
            // M and W advance regardless of flush_E.
            writereg_M_d = writereg_E_w;
            regwrite_M_d = regwrite_E_q;
            memtoreg_M_d = memtoreg_E_q;
            memwrite_M_d = memwrite_E_q;
            valid_M_d    = valid_E_q;

            writereg_W_d = writereg_M_q;
            regwrite_W_d = regwrite_M_q;
            memtoreg_W_d = memtoreg_M_q;
            valid_W_d    = valid_M_q;

            if (bus.flush_E) begin
                // Bubble: regwrite/memwrite low so it can never commit.
                rs_E_d       = c_REG_ZERO;
                rt_E_d       = c_REG_ZERO;
                rd_E_d       = c_REG_ZERO;
                regdst_E_d   = 1'b0;
                regwrite_E_d = 1'b0;
                memtoreg_E_d = 1'b0;
                memwrite_E_d = 1'b0;
                valid_E_d    = 1'b0;
            end else begin
                rs_E_d       = bus.rs_D;
                rt_E_d       = bus.rt_D;
                rd_E_d       = bus.rd_D;
                regdst_E_d   = bus.regdst_D;
                regwrite_E_d = bus.regwrite_D;
                memtoreg_E_d = bus.memtoreg_D;
                memwrite_E_d = bus.memwrite_D;
                valid_E_d    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event counters: clear beats increment, increments saturate.
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!bus.freeze) begin
            if (bus.clr_cnt) begin
                stall_cnt_d = '0;
                flush_cnt_d = '0;
            end else begin
                if (bus.stall_D && (stall_cnt_q != c_CNT_MAX)) begin
                    stall_cnt_d = stall_cnt_q + c_CNT_ONE;
                end
                if (bus.flush_E && (flush_cnt_q != c_CNT_MAX)) begin
                    flush_cnt_d = flush_cnt_q + c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers; reset wins over freeze/flush/clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rs_E_q       <= '0;
            rt_E_q       <= '0;
            rd_E_q       <= '0;
            regdst_E_q   <= 1'b0;
            regwrite_E_q <= 1'b0;
            memtoreg_E_q <= 1'b0;
            memwrite_E_q <= 1'b0;
            valid_E_q    <= 1'b0;

            writereg_M_q <= '0;
            regwrite_M_q <= 1'b0;
            memtoreg_M_q <= 1'b0;
            memwrite_M_q <= 1'b0;
            valid_M_q    <= 1'b0;

            writereg_W_q <= '0;
            regwrite_W_q <= 1'b0;
            memtoreg_W_q <= 1'b0;
            valid_W_q    <= 1'b0;

            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            rs_E_q       <= rs_E_d;
            rt_E_q       <= rt_E_d;
            rd_E_q       <= rd_E_d;
            regdst_E_q   <= regdst_E_d;
            regwrite_E_q <= regwrite_E_d;
            memtoreg_E_q <= memtoreg_E_d;
            memwrite_E_q <= memwrite_E_d;
            valid_E_q    <= valid_E_d;

            writereg_M_q <= writereg_M_d;
            regwrite_M_q <= regwrite_M_d;
            memtoreg_M_q <= memtoreg_M_d;
            memwrite_M_q <= memwrite_M_d;
            valid_M_q    <= valid_M_d;

            writereg_W_q <= writereg_W_d;
            regwrite_W_q <= regwrite_W_d;
            memtoreg_W_q <= memtoreg_W_d;
            valid_W_q    <= valid_W_d;

            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rs_E       = rs_E_q;
    assign bus.rt_E       = rt_E_q;
    assign bus.writereg_E = writereg_E_w;
    assign bus.regwrite_E = regwrite_E_q;
    assign bus.memtoreg_E = memtoreg_E_q;
    assign bus.memwrite_E = memwrite_E_q;
    assign bus.valid_E    = valid_E_q;

    assign bus.writereg_M = writereg_M_q;
    assign bus.regwrite_M = regwrite_M_q;
    assign bus.memtoreg_M = memtoreg_M_q;
    assign bus.memwrite_M = memwrite_M_q;
    assign bus.valid_M    = valid_M_q;

    assign bus.writereg_W = writereg_W_q;
    assign bus.regwrite_W = regwrite_W_q;
    assign bus.memtoreg_W = memtoreg_W_q;
    assign bus.valid_W    = valid_W_q;

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

endmodule : pipe_ctrl_regs
`default_nettype wire

// File: tb/tb_pipe_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_regs
// Description : Directed, table-driven bench for pipe_ctrl_regs (CNT_W=4 so
//               counter saturation is reachable), plus hand-written freeze,
//               saturation and mid-stream reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_regs;

    localparam int c_REG_W = 5;
    localparam int c_CNT_W = 4;
    localparam int c_NVEC  = 7;

    logic clk;
    logic reset;

    int total;
    int bad;

    pipe_ctrl_regs_if #(.REG_W(c_REG_W), .CNT_W(c_CNT_W)) u_if ();

    pipe_ctrl_regs #(.REG_W(c_REG_W), .CNT_W(c_CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One applied cycle: D-side inputs, then expected state after the edge.
    typedef struct {
        int rs, rt, rd, regdst, rw, mtr, mw, st, fl;
        int e_rs, e_rt, e_wr, e_rw, e_mtr, e_mw, e_v;
        int m_wr, m_rw, m_mtr, m_mw, m_v;
        int w_wr, w_rw, w_mtr, w_v;
        int sc, fc;
    } vec_t;

    vec_t vecs [c_NVEC];
    vec_t zero_v;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        u_if.rs_D       = 5'(v.rs);
        u_if.rt_D       = 5'(v.rt);
        u_if.rd_D       = 5'(v.rd);
        u_if.regdst_D   = 1'(v.regdst);
        u_if.regwrite_D = 1'(v.rw);
        u_if.memtoreg_D = 1'(v.mtr);
        u_if.memwrite_D = 1'(v.mw);
        u_if.stall_D    = 1'(v.st);
        u_if.flush_E    = 1'(v.fl);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, ".rs_E"},       32'(u_if.rs_E),       v.e_rs);
        chk({tag, ".rt_E"},       32'(u_if.rt_E),       v.e_rt);
        chk({tag, ".writereg_E"}, 32'(u_if.writereg_E), v.e_wr);
        chk({tag, ".regwrite_E"}, 32'(u_if.regwrite_E), v.e_rw);
        chk({tag, ".memtoreg_E"}, 32'(u_if.memtoreg_E), v.e_mtr);
        chk({tag, ".memwrite_E"}, 32'(u_if.memwrite_E), v.e_mw);
        chk({tag, ".valid_E"},    32'(u_if.valid_E),    v.e_v);
        chk({tag, ".writereg_M"}, 32'(u_if.writereg_M), v.m_wr);
        chk({tag, ".regwrite_M"}, 32'(u_if.regwrite_M), v.m_rw);
        chk({tag, ".memtoreg_M"}, 32'(u_if.memtoreg_M), v.m_mtr);
        chk({tag, ".memwrite_M"}, 32'(u_if.memwrite_M), v.m_mw);
        chk({tag, ".valid_M"},    32'(u_if.valid_M),    v.m_v);
        chk({tag, ".writereg_W"}, 32'(u_if.writereg_W), v.w_wr);
        chk({tag, ".regwrite_W"}, 32'(u_if.regwrite_W), v.w_rw);
        chk({tag, ".memtoreg_W"}, 32'(u_if.memtoreg_W), v.w_mtr);
        chk({tag, ".valid_W"},    32'(u_if.valid_W),    v.w_v);
        chk({tag, ".stall_cnt"},  32'(u_if.stall_cnt),  v.sc);
        chk({tag, ".flush_cnt"},  32'(u_if.flush_cnt),  v.fc);
    endtask

    // Push one instruction whose destination is rt (regdst=0).
    task automatic push_rt(input int rt, input int rw);
        vec_t v;
        v = zero_v;
        v.rt = rt;
        v.rw = rw;
        drive(v);
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        zero_v = '{default: 0};

        //        rs  rt  rd rdst rw mtr mw st fl | eRs eRt eWr eRw eMtr eMw eV | mWr mRw mMtr mMw mV | wWr wRw wMtr wV | sc fc
        vecs[0] = '{ 3,  4,  9, 1, 1, 0, 0, 0, 0,    3,  4,  9, 1, 0, 0, 1,    0, 0, 0, 0, 0,    0, 0, 0, 0,   0, 0};
        vecs[1] = '{ 5, 12, 20, 0, 1, 0, 1, 0, 0,    5, 12, 12, 1, 0, 1, 1,    9, 1, 0, 0, 1,    0, 0, 0, 0,   0, 0};
        vecs[2] = '{ 1, 12, 20, 1, 0, 0, 0, 0, 0,    1, 12, 20, 0, 0, 0, 1,   12, 1, 0, 1, 1,    9, 1, 0, 1,   0, 0};
        vecs[3] = '{ 2, 31,  0, 0, 1, 1, 0, 0, 0,    2, 31, 31, 1, 1, 0, 1,   20, 0, 0, 0, 1,   12, 1, 0, 1,   0, 0};
        vecs[4] = '{31,  7,  8, 1, 1, 0, 1, 1, 1,    0,  0,  0, 0, 0, 0, 0,   31, 1, 1, 0, 1,   20, 0, 0, 1,   1, 1};
        vecs[5] = '{ 0,  0,  0, 1, 1, 0, 0, 0, 0,    0,  0,  0, 1, 0, 0, 1,    0, 0, 0, 0, 0,   31, 1, 1, 1,   1, 1};
        vecs[6] = '{ 6,  3,  5, 1, 1, 0, 0, 0, 0,    6,  3,  5, 1, 0, 0, 1,    0, 1, 0, 0, 1,    0, 0, 0, 0,   1, 1};

        // Reset held with freeze/flush/clear all high: reset must still win.
        reset        = 1'b0;
        u_if.freeze  = 1'b1;
        u_if.clr_cnt = 1'b1;
        drive('{ 7, 7, 7, 1, 1, 1, 1, 1, 1, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0});
        step();
        step();
        check_vec("reset", zero_v);

        reset        = 1'b1;
        u_if.freeze  = 1'b0;
        u_if.clr_cnt = 1'b0;
        drive(zero_v);

        // Table: propagation, regdst select, load-use flush, reg 0 passthrough.
        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i]);
            step();
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Fill pipe so W=7, M=6, E=5.
        push_rt(7, 1);
        push_rt(6, 1);
        push_rt(5, 1);
        chk("fill.writereg_E", 32'(u_if.writereg_E), 5);
        chk("fill.writereg_M", 32'(u_if.writereg_M), 6);
        chk("fill.writereg_W", 32'(u_if.writereg_W), 7);

        // Freeze with flush/stall/clear asserted and new D values: all hold.
        u_if.freeze  = 1'b1;
        u_if.clr_cnt = 1'b1;
        drive('{ 9, 10, 11, 1, 0, 1, 1, 1, 1, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0});
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("frz%0d.writereg_E", i), 32'(u_if.writereg_E), 5);
            chk($sformatf("frz%0d.rt_E", i),       32'(u_if.rt_E),       5);
            chk($sformatf("frz%0d.valid_E", i),    32'(u_if.valid_E),    1);
            chk($sformatf("frz%0d.regwrite_E", i), 32'(u_if.regwrite_E), 1);
            chk($sformatf("frz%0d.writereg_M", i), 32'(u_if.writereg_M), 6);
            chk($sformatf("frz%0d.writereg_W", i), 32'(u_if.writereg_W), 7);
            chk($sformatf("frz%0d.stall_cnt", i),  32'(u_if.stall_cnt),  1);
            chk($sformatf("frz%0d.flush_cnt", i),  32'(u_if.flush_cnt),  1);
        end
        u_if.freeze  = 1'b0;
        u_if.clr_cnt = 1'b0;
        drive('{ 0, 0, 8, 1, 1, 0, 0, 0, 0, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0});
        step();
        chk("thaw1.writereg_E", 32'(u_if.writereg_E), 8);
        chk("thaw1.writereg_M", 32'(u_if.writereg_M), 5);
        chk("thaw1.writereg_W", 32'(u_if.writereg_W), 6);
        u_if.rd_D = 5'd9;
        step();
        chk("thaw2.writereg_E", 32'(u_if.writereg_E), 9);
        chk("thaw2.writereg_M", 32'(u_if.writereg_M), 8);
        chk("thaw2.writereg_W", 32'(u_if.writereg_W), 5);

        // Saturation: stall_cnt starts at 1, 4-bit counter tops out at 15.
        u_if.stall_D = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 13) chk("sat13.stall_cnt", 32'(u_if.stall_cnt), 14);
            if (i == 14) chk("sat14.stall_cnt", 32'(u_if.stall_cnt), 15);
        end
        chk("sat20.stall_cnt", 32'(u_if.stall_cnt), 15);
        chk("sat20.flush_cnt", 32'(u_if.flush_cnt), 1);

        // Clear beats simultaneous increments.
        u_if.clr_cnt = 1'b1;
        u_if.flush_E = 1'b1;
        step();
        chk("clr.stall_cnt", 32'(u_if.stall_cnt), 0);
        chk("clr.flush_cnt", 32'(u_if.flush_cnt), 0);
        u_if.clr_cnt = 1'b0;
        step();
        chk("both.stall_cnt", 32'(u_if.stall_cnt), 1);
        chk("both.flush_cnt", 32'(u_if.flush_cnt), 1);
        u_if.stall_D = 1'b0;
        u_if.flush_E = 1'b0;

        // Refill with real writes, then reset for one edge mid-stream.
        push_rt(1, 1);
        push_rt(2, 1);
        push_rt(3, 1);
        chk("pre_rst.valid_W",    32'(u_if.valid_W),    1);
        chk("pre_rst.regwrite_W", 32'(u_if.regwrite_W), 1);
        chk("pre_rst.writereg_W", 32'(u_if.writereg_W), 1);
        reset       = 1'b0;
        u_if.freeze = 1'b1;
        step();
        check_vec("midrst", zero_v);
        reset       = 1'b1;
        u_if.freeze = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_ctrl_regs
`default_nettype wire

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
- Pipeline control register chain for the 5-stage MIPS core.
- Carries decode-stage control bits and register addresses through the E, M and W stages.
- Sources every stage-state input that the hazard unit reads (rs_E, rt_E, writereg_E/M/W, memtoreg_E/M, regwrite_E/M/W).
- Responds to the hazard unit's flush_E.
- Provides a global freeze for the DES coprocessor, plus saturating stall/flush event counters for debug.

Parameters:
- REG_W, 5, register-address width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- freeze  in  1  global hold from DES coprocessor; all stages and counters hold.
- stall_D  in  1  hazard-unit stall; counted only, does not hold E/M/W.
- flush_E  in  1  hazard-unit clear of E stage.
- rs_D, rt_D, rd_D  in  REG_W each  register fields of the instruction in D.
- regdst_D  in  1  1 = destination is rd, 0 = destination is rt.
- regwrite_D, memtoreg_D, memwrite_D  in  1 each  decode control bits.
- clr_cnt  in  1  synchronous clear of both counters.
- rs_E, rt_E  out  REG_W  source/target registers of the instruction in E.
- writereg_E  out  REG_W  combinational: regdst_E ? rd_E : rt_E.
- regwrite_E, memtoreg_E, memwrite_E  out  1 each  E-stage control.
- writereg_M  out  REG_W; regwrite_M, memtoreg_M, memwrite_M  out  1 each  M-stage state.
- writereg_W  out  REG_W; regwrite_W, memtoreg_W  out  1 each  W-stage state.
- valid_E, valid_M, valid_W  out  1 each  stage holds a real (non-bubble) instruction.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All registered outputs go to 0, including counters and valid bits.
  - Reset overrides freeze, flush_E and clr_cnt.
  - Reset asserted mid-stream discards all in-flight stage contents within that one edge.
- Priority per edge: reset > freeze > flush_E > normal advance.
- freeze==1:
  - Every E/M/W register and both counters hold.
  - flush_E, stall_D and clr_cnt are ignored that cycle.
- Normal advance (freeze==0): in one edge, W<=M, M<=E, E<=D-inputs.
  - E captures rs_D, rt_D, rd_D, regdst_D, regwrite_D, memtoreg_D, memwrite_D; valid_E<=1.
  - M captures writereg_E (the resolved value), regwrite_E, memtoreg_E, memwrite_E, valid_E.
  - W captures writereg_M, regwrite_M, memtoreg_M, valid_M.
- flush_E==1 (freeze==0):
  - E loads a bubble: all addresses 0, all control bits 0, valid_E=0.
  - M and W still advance normally in the same edge.
- stall_D affects only stall_cnt. D/F holding is done elsewhere; the bubble comes via flush_E, which the hazard unit raises together with stall_D.
- Latency:
  - D inputs appear on E outputs 1 cycle later, M 2 cycles later, W 3 cycles later.
  - No combinational path from any D input to any output.
  - writereg_E is a mux of E-stage registers only.
- Bubbles: memwrite and regwrite are 0 in a bubble, so a flushed instruction can never write memory or the register file.
- Counters (freeze==0):
  - clr_cnt==1 clears both counters; clr_cnt has priority over increments in the same edge.
  - Otherwise stall_cnt += stall_D and flush_cnt += flush_E.
  - Each counter saturates at 2^CNT_W-1; it never wraps to 0.
- Simultaneous stall_D and flush_E: both counters increment in the same edge.
- Register 0 receives no special treatment here. The zero-register check is the hazard unit's job, and an address of 0 passes through unchanged.

Test Plan:
- Reset and propagation: hold reset=0 for 2 cycles, then release. All outputs are 0. Drive rs_D=3, rt_D=4, rd_D=9, regdst_D=1, regwrite_D=1:
  - cycle+1: rs_E=3, rt_E=4, writereg_E=9, valid_E=1.
  - cycle+2: writereg_M=9, regwrite_M=1.
  - cycle+3: writereg_W=9, regwrite_W=1.
- Load-use flush: send lw (memtoreg_D=1, rt_D=31, regdst_D=0), then the next instruction with stall_D=1, flush_E=1:
  - the lw advances to M with memtoreg_M=1, writereg_M=31;
  - E becomes a bubble (regwrite_E=0, memwrite_E=0, valid_E=0);
  - stall_cnt=1, flush_cnt=1.
- Freeze: with the pipeline full (writereg_E=5, writereg_M=6, writereg_W=7), hold freeze=1 and flush_E=1 for 3 cycles:
  - all outputs unchanged, counters unchanged;
  - after freeze=0 with flush_E=0, the stages advance one step per cycle.
- Counter saturation: with CNT_W=4, hold stall_D=1 for 20 cycles -> stall_cnt ends at 15. Then clr_cnt=1 with stall_D=1 for one cycle -> stall_cnt=0.
- Reset mid-operation: with the pipeline full, assert reset=0 for one edge -> every output is 0 on the next cycle, including valid_W=0 and regwrite_W=0.
- regdst select: rt_D=12, rd_D=20. regdst_D=0 gives writereg_E=12; regdst_D=1 gives writereg_E=20. writereg_M then follows the captured value 1 cycle later.
